// File: rtl/axis_mwi_if.sv
// AXI4-Stream link carrying one 32-bit word per transfer.
// Latency: none, this is just wiring.
// Backpressure: standard tvalid/tready handshake; the master holds tdata while tvalid && !tready.
// Ports: tvalid (master->slave), tdata[31:0] (master->slave), tready (slave->master).
interface axis_mwi_if;
  logic        tvalid;
  logic [31:0] tdata;
  logic        tready;

  modport master (output tvalid, output tdata, input tready);
  modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/axis_mwi.sv
// Moving-window integrator: running sum (saturated to 32 bits) or floor mean of the last N samples.
// Latency: 1 cycle from input accept to m_axis.tvalid.
// Backpressure: single output register, no skid; s_axis.tready drops while a result is stalled.
// Ports: clk, rst_n (async active-low), s_axis (slave, squared samples in),
//        m_axis (master, window sum/mean out).
// Optional feature: define AXIS_MWI_AVG_EN to output acc >> LOG2_N instead of the saturated sum.
module axis_mwi #(
  parameter int N      = 32,
  parameter int LOG2_N = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  axis_mwi_if.slave   s_axis,
  axis_mwi_if.master  m_axis
);

  localparam int AW = 32 + LOG2_N;
  localparam logic [LOG2_N:0] FILL_LAST = (LOG2_N+1)'(N - 1);

  typedef enum logic {ST_FILL, ST_RUN} state_t;

  state_t              state_q, state_d;
  logic [LOG2_N:0]     fill_q, fill_d;
  logic [LOG2_N-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       acc_q, acc_d;
  logic                tvalid_q, tvalid_d;
  logic [31:0]         tdata_q, tdata_d;
  logic                rst_n_q, rst_n_d;

  // Sample history; not reset, stale entries are ignored while in ST_FILL.
  logic [31:0]         mem_q [N];

  logic                s_ready;
  logic                accept;
  logic [31:0]         evict;
  logic [31:0]         result;

  // Registered reset copy keeps tready low through the reset release edge.
  assign rst_n_d = 1'b1;
  assign s_ready = rst_n_q && (!tvalid_q || m_axis.tready);
  assign accept  = s_axis.tvalid && s_ready;

  assign s_axis.tready = s_ready;
  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tdata  = tdata_q;

  always_comb begin
    state_d  = state_q;
    fill_d   = fill_q;
    wr_ptr_d = wr_ptr_q;
    acc_d    = acc_q;
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    evict    = (state_q == ST_RUN) ? mem_q[wr_ptr_q] : 32'd0;
    result   = 32'd0;

    // Never underflows: evict is always a sample already counted in acc.
    if (accept) begin
      acc_d    = acc_q + AW'(s_axis.tdata) - AW'(evict);
      wr_ptr_d = wr_ptr_q + LOG2_N'(1);
    end

`ifdef AXIS_MWI_AVG_EN
    // Mean divides by N even while filling; the slice is exactly acc >> LOG2_N.
    result = acc_d[LOG2_N +: 32];
`else
    result = (|acc_d[AW-1:32]) ? 32'hFFFF_FFFF : acc_d[31:0];
`endif

    case (state_q)
      ST_FILL: begin
        if (accept) begin
          fill_d = fill_q + (LOG2_N+1)'(1);
          if (fill_q == FILL_LAST) state_d = ST_RUN;
        end
      end
      ST_RUN: state_d = ST_RUN;
      default: state_d = ST_FILL;
    endcase

    // A new accept overwrites the output even when the old result is consumed
    // in the same cycle, which keeps throughput at one sample per cycle.
    if (accept) begin
      tvalid_d = 1'b1;
      tdata_d  = result;
    end else if (m_axis.tready) begin
      tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_FILL;
      fill_q   <= '0;
      wr_ptr_q <= '0;
      acc_q    <= '0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      rst_n_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      fill_q   <= fill_d;
      wr_ptr_q <= wr_ptr_d;
      acc_q    <= acc_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      rst_n_q  <= rst_n_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q] <= s_axis.tdata;
  end

endmodule

// File: tb/tb_axis_mwi.sv
module tb_axis_mwi;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  axis_mwi_if s_if ();
  axis_mwi_if m_if ();

  axis_mwi #(.N(4), .LOG2_N(2)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .s_axis (s_if),
    .m_axis (m_if)
  );

  typedef struct {
    bit          rst;      // reset the block before this vector
    logic [31:0] din;
    logic [31:0] exp_sum;
    logic [31:0] exp_avg;
  } vec_t;

  vec_t vecs [15];

  function automatic logic [31:0] pick(input logic [31:0] s, input logic [31:0] a);
`ifdef AXIS_MWI_AVG_EN
    return a;
`else
    return s;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Hold reset for two cycles and verify the outputs are cleared meanwhile.
  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    s_if.tvalid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("rst_m_tvalid", {31'd0, m_if.tvalid}, 32'd0);
      chk("rst_m_tdata",  m_if.tdata, 32'd0);
      chk("rst_s_tready", {31'd0, s_if.tready}, 32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Present one sample, wait (bounded) for acceptance, leave time at edge+1.
  task automatic send(input logic [31:0] x);
    int n;
    s_if.tvalid = 1'b1;
    s_if.tdata  = x;
    n = 0;
    @(negedge clk);
    while (!s_if.tready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!s_if.tready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: tready stayed %b, required 1", s_if.tready);
    end
    @(posedge clk); #1;
    s_if.tvalid = 1'b0;
  endtask

  initial begin
    // Fill then run, sum/mean
    vecs[0]  = '{1'b1, 32'd1, 32'd1,  32'd0};
    vecs[1]  = '{1'b0, 32'd2, 32'd3,  32'd0};
    vecs[2]  = '{1'b0, 32'd3, 32'd6,  32'd1};
    vecs[3]  = '{1'b0, 32'd4, 32'd10, 32'd2};
    vecs[4]  = '{1'b0, 32'd5, 32'd14, 32'd3};
    vecs[5]  = '{1'b0, 32'd6, 32'd18, 32'd4};
    // Saturation, then proof that acc itself never saturated
    vecs[6]  = '{1'b1, 32'h4000_0000, 32'h4000_0000, 32'h1000_0000};
    vecs[7]  = '{1'b0, 32'h4000_0000, 32'h8000_0000, 32'h2000_0000};
    vecs[8]  = '{1'b0, 32'h4000_0000, 32'hC000_0000, 32'h3000_0000};
    vecs[9]  = '{1'b0, 32'h4000_0000, 32'hFFFF_FFFF, 32'h4000_0000};
    vecs[10] = '{1'b0, 32'd0,         32'hC000_0000, 32'h3000_0000};
    vecs[11] = '{1'b0, 32'd8,         32'h8000_0008, 32'h2000_0002};
    // Window of small values after large ones fully drains
    vecs[12] = '{1'b0, 32'd1,         32'h4000_0009, 32'h1000_0002};
    vecs[13] = '{1'b0, 32'd2,         32'd11,        32'd2};
    vecs[14] = '{1'b0, 32'd3,         32'd14,        32'd3};

    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    m_if.tready = 1'b1;

    // Reset state
    #3;
    chk("init_m_tvalid", {31'd0, m_if.tvalid}, 32'd0);
    chk("init_m_tdata",  m_if.tdata, 32'd0);
    chk("init_s_tready", {31'd0, s_if.tready}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    // tready must still be low until the registered reset copy rises
    #2;
    chk("release_s_tready", {31'd0, s_if.tready}, 32'd0);

    // Table-driven vectors, tready=1, one sample at a time
    for (int i = 0; i < 15; i++) begin
      if (vecs[i].rst) do_reset();
      send(vecs[i].din);
      chk($sformatf("vec%0d_tvalid", i), {31'd0, m_if.tvalid}, 32'd1);
      chk($sformatf("vec%0d_tdata", i), m_if.tdata, pick(vecs[i].exp_sum, vecs[i].exp_avg));
    end
    // Consumed with no new accept: tvalid must clear
    @(posedge clk); #1;
    chk("tvalid_clear", {31'd0, m_if.tvalid}, 32'd0);

    // Backpressure: first result 5 stalls, input 7 waits, then 12
    do_reset();
    m_if.tready = 1'b0;
    send(32'd5);
    s_if.tvalid = 1'b1;
    s_if.tdata  = 32'd7;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("stall_s_tready", {31'd0, s_if.tready}, 32'd0);
      chk("stall_m_tvalid", {31'd0, m_if.tvalid}, 32'd1);
      chk("stall_m_tdata", m_if.tdata, pick(32'd5, 32'd1));
    end
    m_if.tready = 1'b1;
    #1;
    chk("release_s_rdy", {31'd0, s_if.tready}, 32'd1);
    @(posedge clk); #1;
    s_if.tvalid = 1'b0;
    chk("bp_out_tvalid", {31'd0, m_if.tvalid}, 32'd1);
    chk("bp_out_tdata", m_if.tdata, pick(32'd12, 32'd3));
    @(posedge clk); #1;
    chk("bp_no_dup", {31'd0, m_if.tvalid}, 32'd0);
    chk("bp_data_hold", m_if.tdata, pick(32'd12, 32'd3));

    // Back-to-back 1..8, no bubbles
    do_reset();
    @(posedge clk); #1;
    begin
      logic [31:0] exp_s [8];
      logic [31:0] exp_a [8];
      exp_s = '{32'd1, 32'd3, 32'd6, 32'd10, 32'd14, 32'd18, 32'd22, 32'd26};
      exp_a = '{32'd0, 32'd0, 32'd1, 32'd2,  32'd3,  32'd4,  32'd5,  32'd6};
      s_if.tvalid = 1'b1;
      for (int i = 0; i < 8; i++) begin
        s_if.tdata = 32'(i + 1);
        @(negedge clk);
        chk($sformatf("b2b%0d_s_tready", i), {31'd0, s_if.tready}, 32'd1);
        @(posedge clk); #1;
        chk($sformatf("b2b%0d_tvalid", i), {31'd0, m_if.tvalid}, 32'd1);
        chk($sformatf("b2b%0d_tdata", i), m_if.tdata, pick(exp_s[i], exp_a[i]));
      end
      s_if.tvalid = 1'b0;
    end

    // Reset mid-window: 9,9,9 then reset, then 7 must come out alone
    do_reset();
    send(32'd9);
    send(32'd9);
    send(32'd9);
    chk("pre_rst_tdata", m_if.tdata, pick(32'd27, 32'd6));
    do_reset();
    send(32'd7);
    chk("post_rst_tvalid", {31'd0, m_if.tvalid}, 32'd1);
    chk("post_rst_tdata", m_if.tdata, pick(32'd7, 32'd1));
    send(32'd1);
    chk("post_rst_tdata2", m_if.tdata, pick(32'd8, 32'd2));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
